// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder front end.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_arb_fa_bit.sv
// Combinational 1-bit full adder cell shared by all requesters.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_arb.sv
// Two-requester round-robin front end driving one full-adder cell LSB-first
// over WIDTH cycles; results are returned with the issuing requester id.
module serial_add_arb
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_add_arb: WIDTH out of range");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             id_reg;
    logic             last_grant_reg;
    logic             res_valid_reg;
    logic             busy_reg;

    logic             grant;
    logic             can_issue;
    logic             fa_s;
    logic             fa_cout;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant = ~last_grant_reg;
        if (req0_valid && !req1_valid) begin
            grant = REQ0;
        end else if (req1_valid && !req0_valid) begin
            grant = REQ1;
        end
    end

    assign can_issue  = rst_n && (state_reg == IDLE);
    assign req0_ready = can_issue && req0_valid && (grant == REQ0);
    assign req1_ready = can_issue && req1_valid && (grant == REQ1);

    fa_bit u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            sum_reg        <= '0;
            cnt_reg        <= '0;
            carry_reg      <= 1'b0;
            id_reg         <= REQ0;
            last_grant_reg <= REQ1;
            res_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_reg          <= (grant == REQ1) ? req1_a : req0_a;
                        b_reg          <= (grant == REQ1) ? req1_b : req0_b;
                        carry_reg      <= (grant == REQ1) ? req1_cin : req0_cin;
                        id_reg         <= grant;
                        last_grant_reg <= grant;
                        cnt_reg        <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
                    carry_reg <= fa_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_reg;
    assign res_sum   = sum_reg;
    assign res_cout  = carry_reg;
    assign res_id    = id_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_serial_add_arb.sv
// Randomised scoreboard bench: a WIDTH=8 instance for directed cases and a
// WIDTH=4 instance swept over every operand/carry combination.
module tb_serial_add_arb;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // WIDTH=8 instance
    logic       rst8_n, w8_v0, w8_v1, w8_c0, w8_c1, w8_rr;
    logic [7:0] w8_a0, w8_b0, w8_a1, w8_b1, w8_sum;
    logic       w8_rdy0, w8_rdy1, w8_rv, w8_cout, w8_id, w8_busy;

    // WIDTH=4 instance
    logic       rst4_n, w4_v0, w4_v1, w4_c0, w4_c1, w4_rr;
    logic [3:0] w4_a0, w4_b0, w4_a1, w4_b1, w4_sum;
    logic       w4_rdy0, w4_rdy1, w4_rv, w4_cout, w4_id, w4_busy;

    serial_add_arb #(.WIDTH(8)) dut8 (
        .clock(clock), .rst_n(rst8_n),
        .req0_valid(w8_v0), .req0_ready(w8_rdy0), .req0_a(w8_a0), .req0_b(w8_b0), .req0_cin(w8_c0),
        .req1_valid(w8_v1), .req1_ready(w8_rdy1), .req1_a(w8_a1), .req1_b(w8_b1), .req1_cin(w8_c1),
        .res_valid(w8_rv), .res_ready(w8_rr), .res_sum(w8_sum), .res_cout(w8_cout),
        .res_id(w8_id), .busy(w8_busy)
    );

    serial_add_arb #(.WIDTH(4)) dut4 (
        .clock(clock), .rst_n(rst4_n),
        .req0_valid(w4_v0), .req0_ready(w4_rdy0), .req0_a(w4_a0), .req0_b(w4_b0), .req0_cin(w4_c0),
        .req1_valid(w4_v1), .req1_ready(w4_rdy1), .req1_a(w4_a1), .req1_b(w4_b1), .req1_cin(w4_c1),
        .res_valid(w4_rv), .res_ready(w4_rr), .res_sum(w4_sum), .res_cout(w4_cout),
        .res_id(w4_id), .busy(w4_busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q8[$];
    logic [31:0] q4[$];
    logic        last8 = 1'b1;
    logic        last4 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model's arbitration rule: lone requester wins, contention alternates.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return ~last;
    endfunction

    task automatic mon8();
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (rst8_n && w8_rv && w8_rr) begin
                if (q8.size() == 0) begin
                    chk("res8_unexpected", {22'd0, w8_id, w8_cout, w8_sum}, 32'hFFFF_FFFF);
                end else begin
                    e = q8.pop_front();
                    $display("txn w8 id=%0d cout=%0d sum=0x%02h", w8_id, w8_cout, w8_sum);
                    chk("res8", {22'd0, w8_id, w8_cout, w8_sum}, e);
                end
            end
        end
    endtask

    task automatic mon4();
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (rst4_n && w4_rv && w4_rr) begin
                if (q4.size() == 0) begin
                    chk("res4_unexpected", {26'd0, w4_id, w4_cout, w4_sum}, 32'hFFFF_FFFF);
                end else begin
                    e = q4.pop_front();
                    $display("txn w4 id=%0d cout=%0d sum=0x%01h", w4_id, w4_cout, w4_sum);
                    chk("res4", {26'd0, w4_id, w4_cout, w4_sum}, e);
                end
            end
        end
    endtask

    task automatic op8(input logic v0, input logic v1,
                       input logic [7:0] a0, input logic [7:0] b0, input logic c0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic c1,
                       input int hold, input bit keep);
        logic        g;
        logic [8:0]  full;
        logic [31:0] e;
        g = pick(v0, v1, last8);
        w8_v0 = v0; w8_v1 = v1;
        w8_a0 = a0; w8_b0 = b0; w8_c0 = c0;
        w8_a1 = a1; w8_b1 = b1; w8_c1 = c1;
        w8_rr = 1'b0;
        @(negedge clock);
        chk("ready0_w8", w8_rdy0, v0 && (g == 1'b0));
        chk("ready1_w8", w8_rdy1, v1 && (g == 1'b1));
        @(posedge clock); #1;
        last8 = g;
        full = g ? (9'(a1) + 9'(b1) + 9'(c1)) : (9'(a0) + 9'(b0) + 9'(c0));
        e = {22'd0, g, full};
        q8.push_back(e);
        if (!keep) begin
            w8_v0 = 1'b0; w8_v1 = 1'b0;
        end
        for (int j = 1; j <= 8; j++) begin
            @(posedge clock); #1;
            if (j == 7) chk("lat_early_w8", w8_rv, 1'b0);
        end
        chk("lat_w8", w8_rv, 1'b1);
        chk("busy_w8", w8_busy, 1'b1);
        for (int j = 0; j < hold; j++) begin
            @(posedge clock); #1;
            chk("hold_valid_w8", w8_rv, 1'b1);
            chk("hold_data_w8", {22'd0, w8_id, w8_cout, w8_sum}, e);
            chk("hold_ready_w8", {w8_rdy0, w8_rdy1}, 2'b00);
        end
        w8_rr = 1'b1;
        @(posedge clock); #1;
        w8_rr = 1'b0; w8_v0 = 1'b0; w8_v1 = 1'b0;
        chk("release_w8", {w8_rv, w8_busy}, 2'b00);
    endtask

    task automatic op4(input int idx);
        logic [8:0]  c;
        logic [3:0]  ra, rb;
        logic        v0, v1, g;
        logic [4:0]  full;
        int          sel, d;
        c   = idx[8:0];
        sel = $urandom_range(0, 2);
        v0  = (sel != 1);
        v1  = (sel != 0);
        g   = pick(v0, v1, last4);
        ra  = 4'($urandom);
        rb  = 4'($urandom);
        w4_v0 = v0; w4_v1 = v1;
        w4_a0 = g ? ra : c[3:0]; w4_b0 = g ? rb : c[7:4]; w4_c0 = g ? ra[0] : c[8];
        w4_a1 = g ? c[3:0] : ra; w4_b1 = g ? c[7:4] : rb; w4_c1 = g ? c[8] : rb[0];
        @(negedge clock);
        chk("ready0_w4", w4_rdy0, v0 && (g == 1'b0));
        chk("ready1_w4", w4_rdy1, v1 && (g == 1'b1));
        @(posedge clock); #1;
        last4 = g;
        full = 5'(c[3:0]) + 5'(c[7:4]) + 5'(c[8]);
        q4.push_back({26'd0, g, full});
        w4_v0 = 1'b0; w4_v1 = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        d = $urandom_range(0, 2);
        repeat (d) begin @(posedge clock); #1; end
        w4_rr = 1'b1;
        @(posedge clock); #1;
        w4_rr = 1'b0;
    endtask

    initial begin
        rst8_n = 1'b0; rst4_n = 1'b0;
        w8_v0 = 1'b1; w8_v1 = 1'b1; w8_rr = 1'b0;
        w8_a0 = '0; w8_b0 = '0; w8_c0 = 1'b0; w8_a1 = '0; w8_b1 = '0; w8_c1 = 1'b0;
        w4_v0 = 1'b0; w4_v1 = 1'b0; w4_rr = 1'b0;
        w4_a0 = '0; w4_b0 = '0; w4_c0 = 1'b0; w4_a1 = '0; w4_b1 = '0; w4_c1 = 1'b0;
        fork
            mon8();
            mon4();
        join_none

        @(negedge clock);
        chk("reset_ready_w8", {w8_rdy0, w8_rdy1}, 2'b00);
        repeat (2) begin @(posedge clock); #1; end
        rst8_n = 1'b1; rst4_n = 1'b1;
        w8_v0 = 1'b0; w8_v1 = 1'b0;
        chk("reset_outs_w8", {22'd0, w8_rv, w8_busy, w8_id, w8_cout, w8_sum}, 32'd0);

        // wrap-around, carry-in only, then round-robin under contention
        op8(1, 0, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 0, 0, 0);
        op8(0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            op8(1, 1, 8'h12, 8'h34, 0, 8'h80, 8'h80, 0, 0, 1);

        // backpressure with both requesters pending
        op8(1, 1, 8'($urandom), 8'($urandom), 1, 8'($urandom), 8'($urandom), 0, 5, 1);

        // abort mid-shift
        w8_v0 = 1'b1; w8_a0 = 8'hAA; w8_b0 = 8'h55; w8_c0 = 1'b0;
        @(posedge clock); #1;
        w8_v0 = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        rst8_n = 1'b0; w8_v1 = 1'b1;
        @(negedge clock);
        chk("abort_ready_w8", {w8_rdy0, w8_rdy1}, 2'b00);
        @(posedge clock); #1;
        rst8_n = 1'b1; w8_v1 = 1'b0;
        last8 = 1'b1;
        chk("abort_state_w8", {w8_rv, w8_busy}, 2'b00);
        op8(0, 1, 8'h00, 8'h00, 0, 8'h01, 8'h01, 0, 0, 0);

        for (int i = 0; i < 6; i++)
            op8(1'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2), 1'($urandom));

        for (int i = 0; i < 512; i++)
            op4(i);

        repeat (3) @(posedge clock);
        chk("pending_w8", q8.size(), 0);
        chk("pending_w4", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_arb.md
Name: serial_add_arb

Overview:
- Two-requester front end for a single shared 1-bit full-adder cell, run as a bit-serial adder.
- Arbitrates between requesters round-robin and accepts one WIDTH-bit operand pair plus carry-in per operation.
- Sequences the cell LSB-first over WIDTH cycles and returns sum/carry-out tagged with the requester id.
- Sits between the I2C slave register logic and any other datapath client needing occasional additions, with minimal area.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clock  in  1  system clock; all flops rising-edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clock.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  a+b+cin modulo 2^WIDTH.
- res_cout  out  1  carry out of MSB.
- res_id  out  1  requester that issued the operation.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, bit counter=0, carry=0, last_grant=1.
- Reset is checked before every other condition, so it also aborts an operation mid-flight. No partial result is emitted, and neither ready is asserted during the reset cycle.
- IDLE arbitration:
  - If exactly one req*_valid is high, that requester is granted.
  - If both are high, grant the one != last_grant.
  - req*_ready is combinational. It is high only for the granted requester and only in IDLE. The two readys are never high together.
- Handshake at edge k (valid&ready):
  - Latch a, b into shift registers; carry<=cin; id<=grantee; last_grant<=grantee; counter<=0.
  - Go to SHIFT.
- SHIFT, one bit per cycle:
  - fa_bit gets (a[0], b[0], carry).
  - Its sum bit shifts into the MSB of the sum register (right shift); carry<=cout; a, b shift right; counter++.
  - When the counter reaches WIDTH-1 on an edge, go to DONE.
  - Shifts occur at edges k+1..k+WIDTH. res_valid is visible after edge k+WIDTH.
- DONE:
  - res_valid=1. res_sum, res_cout and res_id are held stable until res_ready is sampled high.
  - On res_valid&res_ready: res_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle. Minimum issue interval is WIDTH+2 cycles.
- res_sum, res_cout and res_id keep their last values after the handshake. They are only meaningful while res_valid=1.
- Request inputs are ignored outside IDLE. Operands need only be stable in the handshake cycle.
- A requester dropping valid before ready is not an error. Arbitration re-evaluates every IDLE cycle.
- Carry chain: the final carry register equals res_cout. All arithmetic is unsigned and wraps modulo 2^WIDTH.

Decomposition:
- Package serial_add_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - requester id constants REQ0=0, REQ1=1;
  - WIDTH range limits.
- One sub-module, fa_bit: combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once.
- Counter, shift registers and arbiter stay inline in serial_add_arb.

Test Plan:
- Reset and wrap-around (WIDTH=8), rst_n low 2 cycles, then req0 a=0xFF b=0x01 cin=0: res_valid rises exactly 8 cycles after the handshake edge, with res_sum=0x00, res_cout=1, res_id=0.
- Carry-in only: req1 a=0x00 b=0x00 cin=1 -> res_sum=0x01, res_cout=0, res_id=1. req0_ready stays 0 throughout.
- Simultaneous requests from reset:
  - req0 and req1 both valid, operands (0x12+0x34) and (0x80+0x80): req0 is granted first -> 0x46/0 id0.
  - Then req1 -> 0x00/1 id1.
  - Then, with both still valid, req0 is granted again (round-robin).
- Backpressure: hold res_ready=0 for 5 cycles in DONE. res_valid, res_sum, res_cout and res_id stay stable, and both readys stay 0. Release -> IDLE next cycle.
- Reset mid-operation: assert rst_n=0 at shift cycle 4 of 0xAA+0x55. Next cycle: state IDLE, res_valid=0, busy=0. A following req1 0x01+0x01 gets grant and returns 0x02/0.
- Exhaustive check with WIDTH=4: all 512 (a,b,cin) combinations via random requester choice. Each result must match a+b+cin, with correct res_id and no missed or duplicate results.
